pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It drives the PC write enable, the IF/ID enable and flush, the ID/EX enable and flush, and the EX/MEM bubble. It detects load-use hazards, squashes wrong-path instructions when a jump or taken branch resolves in EX, and freezes the front end while a multi-cycle ALU operation (mult/div) occupies EX. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline datapath and its hazard sequencer.
// The sequencer takes the master modport; the datapath (or a bench) takes the slave modport.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             mc_start;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             ex_jump;
  logic             ex_branch_taken;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_bubble;
  logic             redirect;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  id_rs, id_rt, id_uses_rt, mc_start,
    input  ex_memread, ex_rt, ex_jump, ex_branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    output exmem_bubble, redirect, mc_busy, stall_cnt
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, mc_start,
    output ex_memread, ex_rt, ex_jump, ex_branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
    input  exmem_bubble, redirect, mc_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirect squash,
// multi-cycle ALU freeze, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.master hz
);

  typedef enum logic {RUN = 1'b0, MCWAIT = 1'b1} state_t;

  state_t           state_q;
  logic [7:0]       mc_cnt_q;
  logic             id_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic redir;
  logic lu;
  logic mc_enter;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, redirect;

  assign redir = hz.ex_jump | hz.ex_branch_taken;
  // Register 0 is hard-wired, so a load targeting it can never feed a consumer.
  assign lu    = id_valid_q & hz.ex_memread & (hz.ex_rt != 5'd0) &
                 ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));

  // Outputs are combinational so a stall or flush acts in the cycle the hazard is seen.
  always_comb begin
    // NOTE: every output gets a default first so no path through the priority chain infers a latch.
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    redirect     = 1'b0;
    mc_enter     = 1'b0;

    if (rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
    end else if (state_q == MCWAIT) begin
      // EX holds the multi-cycle op, so redirects and load-use matches are meaningless here.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_bubble = 1'b1;
    end else if (redir) begin
      redirect   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (hz.mc_start && id_valid_q) begin
      mc_enter = 1'b1;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_bubble = exmem_bubble;
  assign hz.redirect     = redirect;
  assign hz.mc_busy      = (state_q == MCWAIT);
  assign hz.stall_cnt    = stall_cnt_q;

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mc_cnt_q    <= 8'd0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mc_enter) begin
            state_q  <= MCWAIT;
            mc_cnt_q <= 8'(MC_LAT - 1);
          end
        end
        MCWAIT: begin
          if (mc_cnt_q == 8'd0) state_q <= RUN;
          else                  mc_cnt_q <= mc_cnt_q - 8'd1;
        end
        default: state_q <= RUN;
      endcase

      if (ifid_flush)   id_valid_q <= 1'b0;
      else if (ifid_en) id_valid_q <= 1'b1;

      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule
